// File: rtl/pix_pair_writeback_pkg.sv
// Shared types and constants for the pixel-pair frame-buffer writer.
package pix_pair_writeback_pkg;

  localparam int PIX_W        = 18;
  localparam int PAIR_W       = 2 * PIX_W;
  localparam int DEF_H_PAIRS  = 320;
  localparam int DEF_V_LINES  = 480;
  localparam int FRAME_PAIRS  = DEF_H_PAIRS * DEF_V_LINES;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pix_pair_writeback_pair_fifo.sv
// Small synchronous FIFO holding pixel pairs between acceptance and ZBT issue.
// Read data is taken straight from the head entry (registered storage, no
// fall-through). A flush empties the FIFO; a push in the flush cycle becomes
// the only entry.
module pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop, wr_en;
  logic [AW-1:0]    wr_idx;

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Pointer and occupancy update; a pop on a full FIFO frees the slot a
  // same-cycle push needs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty && !flush;
    do_push  = push && (!full || do_pop);
    wr_idx   = wr_ptr_q;
    wr_en    = do_push;
    if (flush) begin
      wr_idx   = '0;
      wr_en    = push;
      rd_ptr_d = '0;
      wr_ptr_d = push ? AW'(1) : '0;
      count_d  = push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/pix_pair_writeback.sv
// Writes processed pixel pairs into the ZBT frame buffer in raster order.
// Pairs are buffered in a small FIFO and issued only in cycles where the
// shared ZBT port is granted (wr_slot). mem_we/mem_addr are registered one
// cycle after the issue decision; data follows two cycles later to match
// the ZBT write pipeline.
// Handshake: a pair is taken whenever pair_valid=1 in RUN (no backpressure);
// if the buffer has no room the pair is dropped and overflow latches. A write
// is issued in a cycle with wr_slot=1, state RUN and a non-empty buffer.
module pix_pair_writeback
  import pix_pair_writeback_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int H_PAIRS    = DEF_H_PAIRS,
  parameter int V_LINES    = DEF_V_LINES,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pair_valid,
  input  logic [PAIR_W-1:0] two_proc_pixs,
  input  logic              wr_slot,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PAIR_W-1:0] mem_wdata,
  output logic              frame_done,
  output logic              overflow
);

  localparam int                 N_PAIRS   = H_PAIRS * V_LINES;
  localparam int                 CNT_W     = $clog2(N_PAIRS + 1);
  localparam logic [CNT_W-1:0]   FRAME_CNT = CNT_W'(N_PAIRS);
  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(N_PAIRS - 1);
  localparam logic [ADDR_W-1:0]  BASE      = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  push_cnt_q, push_cnt_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [PAIR_W-1:0] wdata_s1_q, wdata_s1_d;
  logic [PAIR_W-1:0] wdata_s2_q, wdata_s2_d;
  logic [PAIR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PAIR_W-1:0] fifo_rdata;
  logic              accept_window, want_push, room, drop;
  logic [CNT_W-1:0]  push_base;

  pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAIR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (frame_start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (two_proc_pixs),
    .dout  (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Accept/issue decisions and next-state for FSM, counters and write pipe.
  // frame_start restarts the frame: the flush discards buffered pairs and a
  // coincident pair_valid counts as pair 0 of the new frame.
  always_comb begin
    accept_window = (state_q == RUN) || frame_start;
    push_base     = frame_start ? '0 : push_cnt_q;
    fifo_pop      = (state_q == RUN) && !frame_start && wr_slot && !fifo_empty;
    room          = frame_start || !fifo_full || fifo_pop;
    want_push     = accept_window && pair_valid && (push_base < FRAME_CNT);
    fifo_push     = want_push && room;
    drop          = want_push && !room;

    state_d      = state_q;
    push_cnt_d   = push_base + CNT_W'(fifo_push);
    issue_cnt_d  = frame_start ? '0 : issue_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = fifo_pop;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q || drop;
    wdata_s1_d   = fifo_pop ? fifo_rdata : wdata_s1_q;
    wdata_s2_d   = wdata_s1_q;
    mem_wdata_d  = wdata_s2_q;

    if (frame_start) state_d = RUN;

    if (fifo_pop) begin
      mem_addr_d  = BASE + ADDR_W'(issue_cnt_q);
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
      if (issue_cnt_q == LAST_IDX) begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
    end
  end

  // All state registers; reset abandons the frame and clears the write pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      push_cnt_q   <= '0;
      issue_cnt_q  <= '0;
      mem_addr_q   <= BASE;
      mem_we_q     <= 1'b0;
      wdata_s1_q   <= '0;
      wdata_s2_q   <= '0;
      mem_wdata_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      push_cnt_q   <= push_cnt_d;
      issue_cnt_q  <= issue_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      wdata_s1_q   <= wdata_s1_d;
      wdata_s2_q   <= wdata_s2_d;
      mem_wdata_q  <= mem_wdata_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pix_pair_writeback.sv
// Directed bench for pix_pair_writeback: a full-size instance (base 0) and a
// 2x2-pair instance (base 100) share clock and reset.
module tb_pix_pair_writeback;
  import pix_pair_writeback_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A: default frame geometry
  logic              a_frame_start, a_pair_valid, a_wr_slot;
  logic [PAIR_W-1:0] a_pixs;
  logic [18:0]       a_mem_addr;
  logic              a_mem_we, a_frame_done, a_overflow;
  logic [PAIR_W-1:0] a_mem_wdata;

  // instance B: 2 pairs x 2 lines, base address 100
  logic              b_frame_start, b_pair_valid, b_wr_slot;
  logic [PAIR_W-1:0] b_pixs;
  logic [18:0]       b_mem_addr;
  logic              b_mem_we, b_frame_done, b_overflow;
  logic [PAIR_W-1:0] b_mem_wdata;

  pix_pair_writeback u_dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (a_frame_start),
    .pair_valid    (a_pair_valid),
    .two_proc_pixs (a_pixs),
    .wr_slot       (a_wr_slot),
    .mem_addr      (a_mem_addr),
    .mem_we        (a_mem_we),
    .mem_wdata     (a_mem_wdata),
    .frame_done    (a_frame_done),
    .overflow      (a_overflow)
  );

  pix_pair_writeback #(
    .ADDR_W    (19),
    .H_PAIRS   (2),
    .V_LINES   (2),
    .BASE_ADDR (100),
    .FIFO_DEPTH(4)
  ) u_small (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (b_frame_start),
    .pair_valid    (b_pair_valid),
    .two_proc_pixs (b_pixs),
    .wr_slot       (b_wr_slot),
    .mem_addr      (b_mem_addr),
    .mem_we        (b_mem_we),
    .mem_wdata     (b_mem_wdata),
    .frame_done    (b_frame_done),
    .overflow      (b_overflow)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [PAIR_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_frame_start = 1'b0; a_pair_valid = 1'b0; a_wr_slot = 1'b0; a_pixs = '0;
    b_frame_start = 1'b0; b_pair_valid = 1'b0; b_wr_slot = 1'b0; b_pixs = '0;
  endtask

  // watchdog: the directed sequence is only a few hundred cycles
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int j;
    logic exp_we;
    logic [PAIR_W-1:0] exp_wd;

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // ---- reset state ----
    chk("rst_a_we",    64'(a_mem_we),     64'(0));
    chk("rst_a_addr",  64'(a_mem_addr),   64'(0));
    chk("rst_a_wdata", 64'(a_mem_wdata),  64'(0));
    chk("rst_a_done",  64'(a_frame_done), 64'(0));
    chk("rst_a_ovf",   64'(a_overflow),   64'(0));
    chk("rst_b_addr",  64'(b_mem_addr),   64'(100));
    chk("rst_b_state", 64'(u_small.state_q), 64'(IDLE));

    // ---- test 1: four back-to-back pairs, slot always granted ----
    a_frame_start = 1'b1; a_wr_slot = 1'b1;
    tick();
    a_frame_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a_pair_valid = (k < 4);
      a_pixs       = PAIR_W'(k + 1);
      a_wr_slot    = 1'b1;
      if (k < 4) exp_q.push_back(PAIR_W'(k + 1));
      tick();
      j = k + 1;
      exp_we = (j >= 2) && (j <= 5);
      chk("t1_we", 64'(a_mem_we), 64'(exp_we));
      if (exp_we) chk("t1_addr", 64'(a_mem_addr), 64'(j - 2));
      if (j >= 4 && j <= 7) begin
        exp_wd = exp_q.pop_front();
        chk("t1_wdata", 64'(a_mem_wdata), 64'(exp_wd));
      end else if (j < 4) begin
        chk("t1_wdata_pre", 64'(a_mem_wdata), 64'(0));
      end
      chk("t1_ovf", 64'(a_overflow), 64'(0));
    end
    a_pair_valid = 1'b0;

    // ---- test 2: slot every other cycle, pairs every cycle -> overflow ----
    // accepted pairs 0x100..0x106, pair 0x107 hits a full FIFO with no pop
    a_frame_start = 1'b1; a_wr_slot = 1'b0;
    tick();
    a_frame_start = 1'b0;
    chk("t2_restart_we", 64'(a_mem_we), 64'(0));
    for (int k = 0; k < 17; k++) begin
      a_pair_valid = (k < 8);
      a_pixs       = PAIR_W'(36'h100 + k);
      a_wr_slot    = (k % 2 == 0);
      tick();
      j = k + 1;
      exp_we = (j % 2 == 1) && (j >= 3) && (j <= 15);
      chk("t2_we", 64'(a_mem_we), 64'(exp_we));
      if (exp_we) chk("t2_addr", 64'(a_mem_addr), 64'((j - 3) / 2));
      chk("t2_ovf", 64'(a_overflow), 64'(j >= 8));
      if (j % 2 == 1 && j >= 5) chk("t2_wdata", 64'(a_mem_wdata), 64'(36'h100 + (j - 5) / 2));
    end
    a_pair_valid = 1'b0; a_wr_slot = 1'b0;

    // ---- test 3: 2x2 frame, base 100, frame_done, 5th pair ignored ----
    b_frame_start = 1'b1;
    tick();
    b_frame_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      b_pair_valid = (k < 4) || (k == 6);
      b_pixs       = PAIR_W'(36'h200 + k);
      b_wr_slot    = 1'b1;
      tick();
      j = k + 1;
      exp_we = (j >= 2) && (j <= 5);
      chk("t3_we", 64'(b_mem_we), 64'(exp_we));
      if (exp_we) chk("t3_addr", 64'(b_mem_addr), 64'(100 + j - 2));
      chk("t3_done", 64'(b_frame_done), 64'(j == 5));
      chk("t3_state", 64'(u_small.state_q), (j >= 5) ? 64'(IDLE) : 64'(RUN));
      chk("t3_ovf", 64'(b_overflow), 64'(0));
      if (j < 4)       exp_wd = '0;
      else if (j <= 7) exp_wd = PAIR_W'(36'h200 + j - 4);
      else             exp_wd = PAIR_W'(36'h203);
      chk("t3_wdata", 64'(b_mem_wdata), 64'(exp_wd));
    end
    b_pair_valid = 1'b0; b_wr_slot = 1'b0;

    // ---- test 4: frame_start + pair_valid with two pairs buffered ----
    a_wr_slot = 1'b0; a_pair_valid = 1'b1;
    a_pixs = PAIR_W'(36'hAA1);
    tick();
    chk("t4_buf1_we", 64'(a_mem_we), 64'(0));
    a_pixs = PAIR_W'(36'hAA2);
    tick();
    chk("t4_buf2_we", 64'(a_mem_we), 64'(0));
    a_frame_start = 1'b1; a_pair_valid = 1'b1; a_pixs = PAIR_W'(36'hBEEF); a_wr_slot = 1'b1;
    tick();
    a_frame_start = 1'b0; a_pair_valid = 1'b0;
    chk("t4_s1_we", 64'(a_mem_we), 64'(0));
    for (int m = 0; m < 5; m++) begin
      tick();
      chk("t4_we", 64'(a_mem_we), 64'(m == 0));
      if (m == 0) chk("t4_addr", 64'(a_mem_addr), 64'(0));
      if (m >= 2) chk("t4_wdata", 64'(a_mem_wdata), 64'(36'hBEEF));
    end
    chk("t4_ovf_sticky", 64'(a_overflow), 64'(1));

    // ---- test 5: reset mid-frame with FIFO full ----
    a_wr_slot = 1'b0; a_pair_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_pixs = PAIR_W'(36'h300 + i);
      tick();
    end
    a_pair_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("t5_rst_we",    64'(a_mem_we),     64'(0));
    chk("t5_rst_ovf",   64'(a_overflow),   64'(0));
    chk("t5_rst_addr",  64'(a_mem_addr),   64'(0));
    chk("t5_rst_wdata", 64'(a_mem_wdata),  64'(0));
    chk("t5_rst_done",  64'(a_frame_done), 64'(0));
    reset = 1'b0; a_wr_slot = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_idle_we", 64'(a_mem_we), 64'(0));
    end
    a_frame_start = 1'b1; a_pair_valid = 1'b1; a_pixs = PAIR_W'(36'h5A5);
    tick();
    a_frame_start = 1'b0; a_pair_valid = 1'b0;
    chk("t5_s1_we", 64'(a_mem_we), 64'(0));
    tick();
    chk("t5_we",   64'(a_mem_we),   64'(1));
    chk("t5_addr", 64'(a_mem_addr), 64'(0));
    tick();
    chk("t5_we_off", 64'(a_mem_we), 64'(0));
    tick();
    chk("t5_wdata", 64'(a_mem_wdata), 64'(36'h5A5));
    chk("t5_ovf",   64'(a_overflow),  64'(0));

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
